// File: rtl/boot_rom_req_arbiter_pkg.sv
// Shared types and constants for the boot ROM request arbiter.
// Pending-response bundle plus ROM window defaults.
package boot_rom_arb_pkg;

  localparam int unsigned IDX_W = 8;

  localparam logic [31:0] ROM_BASE_DEF  = 32'h1A00_0000;
  localparam int unsigned ROM_AW_DEF    = 13;
  localparam int unsigned NUM_M_DEF     = 2;
  localparam logic [31:0] ERR_RDATA     = 32'h0;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [IDX_W-1:0] idx;
  } resp_t;

  function automatic logic out_of_window(
    input logic [31:0] add,
    input logic [31:0] base,
    input int unsigned aw
  );
    logic [31:0] off;
    logic [31:0] msk;
    off = add - base;
    msk = ~((32'h1 << aw) - 32'h1);
    return |(off & msk);
  endfunction

endpackage

// File: rtl/boot_rom_req_arbiter_if.sv
// Master-side TCDM bundle and ROM-side port of the arbiter.
// slave: arbiter view; master: requesters plus ROM.
interface boot_rom_req_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]       m_req;
  logic [NUM_MASTERS-1:0][31:0] m_add;
  logic [NUM_MASTERS-1:0]       m_wen;
  logic [NUM_MASTERS-1:0]       m_gnt;
  logic [NUM_MASTERS-1:0]       m_r_valid;
  logic [NUM_MASTERS-1:0][31:0] m_r_rdata;
  logic [NUM_MASTERS-1:0]       m_r_opc;

  logic        rom_req;
  logic [31:0] rom_add;
  logic        rom_gnt;
  logic        rom_r_valid;
  logic [31:0] rom_r_rdata;

  modport slave (
    input  m_req,
    input  m_add,
    input  m_wen,
    output m_gnt,
    output m_r_valid,
    output m_r_rdata,
    output m_r_opc,
    output rom_req,
    output rom_add,
    input  rom_gnt,
    input  rom_r_valid,
    input  rom_r_rdata
  );

  modport master (
    output m_req,
    output m_add,
    output m_wen,
    input  m_gnt,
    input  m_r_valid,
    input  m_r_rdata,
    input  m_r_opc,
    input  rom_req,
    input  rom_add,
    output rom_gnt,
    output rom_r_valid,
    output rom_r_rdata
  );

endinterface

// File: rtl/boot_rom_req_arbiter_rr_arb.sv
// Round-robin pick: first request at or after the pointer,
// wrapping modulo N. Purely combinational.
module boot_rom_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (!valid && req[(int'(ptr) + k) % int'(N)]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % int'(N));
        gnt[(int'(ptr) + k) % int'(N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_rom_req_arbiter.sv
// N-to-1 boot ROM arbiter: round-robin grant, local error
// termination of writes/out-of-window reads, 1-cycle response.
module boot_rom_req_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = NUM_M_DEF,
  parameter int unsigned ROM_ADDR_WIDTH = ROM_AW_DEF,
  parameter logic [31:0] ROM_BASE_ADDR  = ROM_BASE_DEF
) (
  input logic                  clk_i,
  input logic                  rst_i,
  boot_rom_req_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] err;
  logic [NUM_MASTERS-1:0] pick;
  logic [IW-1:0]          win;
  logic                   any;
  logic                   win_err;
  logic                   grant;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_nxt;
  resp_t                  pend_q;
  logic                   unused_rvalid;

  assign unused_rvalid = bus.rom_r_valid;

  always_comb begin
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      err[i] = !bus.m_wen[i] ||
               out_of_window(bus.m_add[i], ROM_BASE_ADDR,
                             ROM_ADDR_WIDTH);
    end
  end

  boot_rom_rr_arb #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr (
    .req   (bus.m_req),
    .ptr   (ptr_q),
    .gnt   (pick),
    .idx   (win),
    .valid (any)
  );

  // Errors never wait on the ROM; only reads depend on rom_gnt.
  assign win_err     = err[win];
  assign grant       = any && (win_err || bus.rom_gnt);
  assign bus.m_gnt   = grant ? pick : '0;
  assign bus.rom_req = any && !win_err;
  assign bus.rom_add = bus.m_add[win];

  assign ptr_nxt = (int'(win) == int'(NUM_MASTERS) - 1)
                 ? '0 : win + IW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      pend_q <= '0;
    end else if (grant) begin
      ptr_q        <= ptr_nxt;
      pend_q.valid <= 1'b1;
      pend_q.err   <= win_err;
      pend_q.idx   <= IDX_W'(win);
    end else begin
      pend_q <= '0;
    end
  end

  always_comb begin
    bus.m_r_valid = '0;
    bus.m_r_rdata = '0;
    bus.m_r_opc   = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (pend_q.valid && pend_q.idx == IDX_W'(i)) begin
        bus.m_r_valid[i] = 1'b1;
        bus.m_r_opc[i]   = pend_q.err;
        bus.m_r_rdata[i] = pend_q.err ? ERR_RDATA
                                      : bus.rom_r_rdata;
      end
    end
  end

endmodule

// File: tb/tb_boot_rom_req_arbiter.sv
// Scoreboard bench for boot_rom_req_arbiter (2 masters).
// Grant checked same cycle, response checked next cycle.
module tb_boot_rom_req_arbiter;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h1A00_0000;
  localparam logic [31:0] WIN  = 32'h0000_2000;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   ptr_m;
  exp_t q[$];

  logic [N-1:0]       cur_req;
  logic [N-1:0]       cur_wen;
  logic [31:0]        cur_add [N];

  boot_rom_req_arbiter_if #(.NUM_MASTERS(N)) bus ();

  boot_rom_req_arbiter #(
    .NUM_MASTERS    (N),
    .ROM_ADDR_WIDTH (13),
    .ROM_BASE_ADDR  (BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hB007, a[15:0] ^ 16'h5A5A};
  endfunction

  always @(posedge clk) begin
    bus.rom_r_valid <= bus.rom_req && bus.rom_gnt;
    bus.rom_r_rdata <= rom_word(bus.rom_add);
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] req,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] wen, input logic rg);
    int          w;
    logic        any;
    logic        e;
    logic        g;
    logic [31:0] a;
    logic [31:0] off;
    logic [N-1:0] gv;
    exp_t        x;
    logic        have;
    @(negedge clk);
    rst         = r;
    bus.m_req   = req;
    bus.m_add[0] = a0;
    bus.m_add[1] = a1;
    bus.m_wen   = wen;
    bus.rom_gnt = rg;
    #1;
    any = 1'b0;
    w   = 0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(ptr_m + k) % N]) begin
        any = 1'b1;
        w   = (ptr_m + k) % N;
      end
    end
    a   = (w == 0) ? a0 : a1;
    off = a - BASE;
    e   = !wen[w] || (off >= WIN);
    g   = any && (e || rg);
    gv  = '0;
    if (g) gv[w] = 1'b1;
    chk("gnt", {30'b0, bus.m_gnt}, {30'b0, gv});
    chk("rom_req", {31'b0, bus.rom_req}, {31'b0, any && !e});
    if (any && !e) chk("rom_add", bus.rom_add, a);
    if (r) begin
      q.delete();
      ptr_m = 0;
    end else if (g) begin
      x.idx  = w;
      x.err  = e;
      x.data = e ? 32'h0 : rom_word(a);
      q.push_back(x);
      ptr_m = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    have = (q.size() > 0);
    if (have) x = q.pop_front();
    for (int m = 0; m < N; m++) begin
      logic v;
      v = have && (x.idx == m);
      chk($sformatf("r_valid[%0d]", m),
          {31'b0, bus.m_r_valid[m]}, {31'b0, v});
      chk($sformatf("r_opc[%0d]", m),
          {31'b0, bus.m_r_opc[m]}, {31'b0, v && x.err});
      chk($sformatf("r_rdata[%0d]", m),
          bus.m_r_rdata[m], v ? x.data : 32'h0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ptr_m   = 0;
    rst     = 1'b1;
    bus.m_req = '0;
    bus.m_add[0] = '0;
    bus.m_add[1] = '0;
    bus.m_wen = '1;
    bus.rom_gnt = 1'b1;
    step(1, 2'b11, BASE, BASE + 4, 2'b11, 1);
    step(1, 2'b11, BASE, BASE + 4, 2'b11, 1);
    for (int i = 0; i < 4; i++)
      step(0, 2'b11, BASE, BASE + 4, 2'b11, 1);
    step(0, 2'b00, BASE, BASE, 2'b11, 1);
    step(0, 2'b10, BASE, BASE + 32'h10, 2'b01, 1);
    step(0, 2'b00, BASE, BASE, 2'b11, 1);
    step(0, 2'b01, BASE + 32'h2000, BASE, 2'b11, 1);
    step(0, 2'b01, BASE + 32'h1FFC, BASE, 2'b11, 1);
    step(0, 2'b01, 32'h19FF_FFFC, BASE, 2'b11, 1);
    for (int i = 0; i < 3; i++)
      step(0, 2'b01, BASE + 32'h40, BASE, 2'b11, 0);
    step(0, 2'b01, BASE + 32'h40, BASE, 2'b11, 1);
    step(0, 2'b00, BASE, BASE, 2'b11, 1);
    step(0, 2'b11, BASE + 8, BASE + 12, 2'b11, 0);
    step(0, 2'b11, BASE + 8, BASE + 12, 2'b11, 1);
    step(0, 2'b10, BASE, BASE + 32'h20, 2'b11, 1);
    step(1, 2'b10, BASE, BASE + 32'h20, 2'b11, 1);
    step(0, 2'b11, BASE, BASE + 4, 2'b11, 1);
    cur_req = '0;
    cur_wen = '1;
    cur_add[0] = BASE;
    cur_add[1] = BASE;
    for (int c = 0; c < 80; c++) begin
      logic [N-1:0] gs;
      for (int m = 0; m < N; m++) begin
        if (!cur_req[m] || (gs[m] === 1'b1)) begin
          cur_req[m] = ($urandom_range(0, 3) != 0);
          cur_wen[m] = ($urandom_range(0, 5) != 0);
          cur_add[m] = ($urandom_range(0, 7) == 0)
                     ? BASE + 32'h2000 + {$urandom_range(0, 255), 2'b00}
                     : BASE + {$urandom_range(0, 2047), 2'b00};
        end
      end
      step(0, cur_req, cur_add[0], cur_add[1], cur_wen,
           ($urandom_range(0, 3) != 0));
      #2;
      gs = '0;
      gs = bus.m_gnt;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
